// File: rtl/bm_stmt_result_collector_if.sv
// Stimulus, upstream results and collector verdicts for one statement-stage checker.
// master = stimulus/upstream side, slave = collector.
interface bm_stmt_result_collector_if #(
   parameter int BITS = 4
);
   logic            start;
   logic [BITS-1:0] a_in;
   logic            b_in;
   logic [BITS-1:0] out0;
   logic            out1;
   logic            out5;
   logic            out7;
   logic            out9;
   logic            busy;
   logic            done;
   logic [4:0]      err_count;
   logic            err_valid;
   logic [4:0]      first_err_idx;
   logic [7:0]      signature;

   modport master (
      output start, a_in, b_in, out0, out1, out5, out7, out9,
      input  busy, done, err_count, err_valid, first_err_idx, signature
   );

   modport slave (
      input  start, a_in, b_in, out0, out1, out5, out7, out9,
      output busy, done, err_count, err_valid, first_err_idx, signature
   );
endinterface

// File: rtl/bm_stmt_result_collector.sv
// Checks SAMPLES cycles of upstream statement results against a_in/b_in delayed one cycle; MISR-signs them.
// Verdicts land SAMPLES+2 edges after start; no backpressure, start is ignored while a run is in flight.
module bm_stmt_result_collector #(
   parameter int BITS    = 4,
   parameter int SAMPLES = 16
) (
   input logic                      clock,
   input logic                      reset_n,
   bm_stmt_result_collector_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [4:0] LAST_IDX = 5'(SAMPLES - 1);
   localparam logic [4:0] CNT_MAX  = 5'h1f;

   logic [1:0]      state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [4:0]      err_cnt_q, err_cnt_d;
   logic            err_vld_q, err_vld_d;
   logic [4:0]      first_idx_q, first_idx_d;
   logic [7:0]      sig_q, sig_d;
   logic [BITS-1:0] a_d_q;
   logic            b_d_q;

   logic [BITS-1:0] exp_out0;
   logic            exp_out1;
   logic            exp_out7;
   logic            mismatch;
   logic [7:0]      obs;
   logic            misr_fb;

   // Upstream results correspond to the stimulus of the previous cycle.
   always_comb begin
      exp_out0 = ~a_d_q;
      exp_out1 = ~b_d_q;
      exp_out7 = b_d_q ? (|a_d_q) : 1'b1;
      mismatch = (bus.out0 != exp_out0) |
                 (bus.out1 != exp_out1) |
                 (bus.out5 != exp_out1) |
                 (bus.out7 != exp_out7) |
                 (bus.out9 != 1'b1);
      obs      = 8'({bus.out0, bus.out1, bus.out5, bus.out7, bus.out9});
      misr_fb  = sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_cnt_d   = err_cnt_q;
      err_vld_d   = err_vld_q;
      first_idx_d = first_idx_q;
      sig_d       = sig_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d     = S_PRIME;
               cnt_d       = 5'd0;
               err_cnt_d   = 5'd0;
               err_vld_d   = 1'b0;
               first_idx_d = 5'd0;
               sig_d       = 8'hFF;
            end
         end
         S_PRIME: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            sig_d = {sig_q[6:0], misr_fb} ^ obs;
            cnt_d = cnt_q + 5'd1;
            if (mismatch) begin
               if (err_cnt_q != CNT_MAX) begin
                  err_cnt_d = err_cnt_q + 5'd1;
               end
               if (!err_vld_q) begin
                  err_vld_d   = 1'b1;
                  first_idx_d = cnt_q;
               end
            end
            if (cnt_q == LAST_IDX) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!bus.start) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 5'd0;
         err_cnt_q   <= 5'd0;
         err_vld_q   <= 1'b0;
         first_idx_q <= 5'd0;
         sig_q       <= 8'h00;
         a_d_q       <= '0;
         b_d_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_vld_q   <= err_vld_d;
         first_idx_q <= first_idx_d;
         sig_q       <= sig_d;
         a_d_q       <= bus.a_in;
         b_d_q       <= bus.b_in;
      end
   end

   assign bus.busy          = (state_q == S_PRIME) || (state_q == S_CHECK);
   assign bus.done          = (state_q == S_DONE);
   assign bus.err_count     = err_cnt_q;
   assign bus.err_valid     = err_vld_q;
   assign bus.first_err_idx = first_idx_q;
   assign bus.signature     = sig_q;

endmodule

// File: doc/bm_stmt_result_collector.md
BM_STMT_RESULT_COLLECTOR -- requirements
Module: bm_stmt_result_collector

Interface
REQ-001 SHALL have parameter: BITS, 4, operand width; fixed at 4 for this benchmark.
REQ-002 SHALL have parameter: SAMPLES, 16, number of checked cycles per run; legal range 2..31.
REQ-003 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  run request, level-sampled in IDLE.
REQ-006 SHALL have port: a_in  input  BITS  stimulus being applied to the upstream statement stage this cycle.
REQ-007 SHALL have port: b_in  input  1  stimulus being applied to the upstream statement stage this cycle.
REQ-008 SHALL have port: out0  input  BITS  upstream case-decoder result.
REQ-009 SHALL have port: out1, out5, out7, out9  input  1 each  upstream single-bit results.
REQ-010 SHALL have port: busy  output  1  high in PRIME and CHECK.
REQ-011 SHALL have port: done  output  1  high in DONE.
REQ-012 SHALL have port: err_count  output  5  mismatching samples in current or last run.
REQ-013 SHALL have port: err_valid  output  1  at least one mismatch seen in current or last run.
REQ-014 SHALL have port: first_err_idx  output  5  sample index (0-based) of first mismatch.
REQ-015 SHALL have port: signature  output  8  MISR over checked samples.

Function
REQ-016 SHALL register a_in and b_in every cycle into a_d/b_d (one-cycle delay matching upstream register latency), independent of state.
REQ-017 SHALL implement states IDLE, PRIME, CHECK, DONE.
REQ-018 IDLE: start=1 at an edge -> PRIME; same edge clears err_count, err_valid, first_err_idx, sample counter, and loads signature 8'hFF.
REQ-019 PRIME: unconditional -> CHECK after one cycle; no comparison performed.
REQ-020 CHECK: each edge performs one comparison and increments sample counter; after sample SAMPLES-1 is checked -> DONE.
REQ-021 DONE: held while start=1; start=0 at an edge -> IDLE; results held unchanged in IDLE and DONE.
REQ-022 start SHALL be ignored in PRIME and CHECK.
REQ-023 Expected values at a CHECK edge: out0 = ~a_d; out1 = ~b_d; out5 = ~b_d; out7 = 1 if b_d=0, else 0 if a_d=4'b0000, else 1; out9 = 1.
REQ-024 A sample SHALL mismatch if any of out0, out1, out5, out7, out9 differs from expected.
REQ-025 On a mismatch: err_count +1; if err_valid=0, set err_valid=1 and first_err_idx = current sample index; later mismatches SHALL NOT change first_err_idx.
REQ-026 err_count SHALL NOT wrap; SAMPLES<=31 guarantees no overflow.
REQ-027 Signature update per CHECK edge: sig_next = {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} XOR {out0, out1, out5, out7, out9}.
REQ-028 Timing: start seen at edge k -> busy from k; checks at edges k+2..k+SAMPLES+1; done=1 after edge k+SAMPLES+1.

Reset
REQ-029 reset_n=0 at an edge SHALL force IDLE and zero busy, done, err_count, err_valid, first_err_idx, signature, sample counter, a_d, b_d, regardless of state.
REQ-030 Reset mid-run SHALL abort the run; no partial results retained; a new start is required.
REQ-031 reset_n SHALL take priority over start.

Verification
REQ-032 Correct upstream model, a_in sweeps 0..15, b_in alternates from 0, start pulse at edge k -> done=1 after edge k+17, err_count=0, err_valid=0, signature matches reference MISR model.
REQ-033 Same run with out0 forced to 4'b0000 at sample 5 only -> err_count=1, err_valid=1, first_err_idx=5.
REQ-034 out9 forced 0 whole run -> err_count=16, first_err_idx=0.
REQ-035 a_in=4'b0000, b_in=1 whole run, correct model -> out7 expected 0 each sample, err_count=0.
REQ-036 reset_n=0 during CHECK at sample 8 -> next cycle busy=0, done=0, err_count=0, signature=8'h00; start re-pulsed -> full 16-sample run completes normally.
REQ-037 start held high through DONE -> stays DONE, no new run; start re-asserted during CHECK -> no effect on sample count.
